// File: rtl/dds_pkg.sv
// Shared definitions for the multi-channel DDS: config encodings, default widths
// and the quarter-wave sine table generator.
package dds_pkg;

  localparam int DEF_N_CH   = 4;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_SINE_W = 12;

  typedef enum logic [1:0] {
    CFG_FTW = 2'd0,
    CFG_OFF = 2'd1,
    CFG_CLR = 2'd2,
    CFG_NOP = 2'd3
  } cfg_sel_e;

  localparam int     FRAC_W      = 30;
  localparam longint PI_HALF_Q30 = 64'sd1686629713;

  // round((2^(sine_w-1)-1) * sin(pi/2 * (k+0.5) / 2^addr_w)), evaluated in Q30
  // fixed point with a Taylor series so it folds to a constant at elaboration.
  function automatic int rom_value(input int k, input int addr_w, input int sine_w);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    x    = (PI_HALF_Q30 * longint'(2 * k + 1)) >>> (addr_w + 1);
    x2   = (x * x) >>> FRAC_W;
    term = x;
    sum  = x;
    for (int n = 1; n <= 9; n++) begin
      term = -((term * x2) >>> FRAC_W) / longint'(4 * n * n + 2 * n);
      sum  = sum + term;
    end
    amp = (longint'(1) <<< (sine_w - 1)) - 1;
    return int'((amp * sum + (longint'(1) <<< (FRAC_W - 1))) >>> FRAC_W);
  endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine magnitude ROM with a registered, enable-gated read port.
// Entries are offset by half an LSB in phase so that ~addr mirrors exactly.
module quarter_sine_rom
  import dds_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SINE_W = DEF_SINE_W
) (
  input  logic              clock,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [SINE_W-2:0] data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [SINE_W-2:0] rom_table [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam int VALUE = rom_value(gi, ADDR_W, SINE_W);
    assign rom_table[gi] = VALUE[SINE_W-2:0];
  end

  always_ff @(posedge clock) begin
    if (en) begin
      data <= rom_table[addr];
    end
  end

endmodule

// File: rtl/multi_channel_dds.sv
// Time-multiplexed N-channel DDS sine source: round-robin issue of per-channel
// phase, quadrant fold, shared quarter-wave ROM and sign restore on a valid/ready stream.
module multi_channel_dds
  import dds_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SINE_W = DEF_SINE_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [ACC_W-1:0]  cfg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SINE_W-1:0] out_sample,
  output logic [CH_W-1:0]   out_ch
);

  logic [ACC_W-1:0] acc [N_CH];
  logic [ACC_W-1:0] ftw [N_CH];
  logic [ACC_W-1:0] off [N_CH];
  logic [CH_W-1:0]  ptr;
  logic [N_CH-1:0]  cfg_hit;

  logic stall;
  logic issue;

  logic [1:0]              quad;
  logic [ADDR_W-1:0]       addr_raw;
  logic [ADDR_W-1:0]       addr_fold;
  logic [ACC_W-ADDR_W-3:0] ph_unused;

  logic              v1;
  logic              neg1;
  logic [ADDR_W-1:0] addr1;
  logic [CH_W-1:0]   ch1;
  logic              v2;
  logic              neg2;
  logic [CH_W-1:0]   ch2;
  logic [SINE_W-2:0] mag2;
  logic [SINE_W-1:0] mag_ext;

  assign stall = out_valid && !out_ready;
  assign issue = enable && !stall;

  // Out-of-range channel indices never match, so such writes are dropped.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_hit
    assign cfg_hit[gi] = cfg_we && (cfg_ch == CH_W'(gi));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        acc[c] <= '0;
        ftw[c] <= '0;
        off[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (cfg_hit[c]) begin
          case (cfg_sel)
            CFG_FTW: ftw[c] <= cfg_data;
            CFG_OFF: off[c] <= cfg_data;
            default: ;
          endcase
        end
        // Clear has priority over the accumulator advance of the same cycle.
        if (cfg_hit[c] && (cfg_sel == CFG_CLR)) begin
          acc[c] <= '0;
        end else if (issue && (ptr == CH_W'(c))) begin
          acc[c] <= acc[c] + ftw[c];
        end
      end
    end
  end

  assign {quad, addr_raw, ph_unused} = acc[ptr] + off[ptr];
  assign addr_fold = quad[0] ? ~addr_raw : addr_raw;
  assign mag_ext   = {1'b0, mag2};

  quarter_sine_rom #(
    .ADDR_W (ADDR_W),
    .SINE_W (SINE_W)
  ) u_rom (
    .clock (clock),
    .en    (!stall),
    .addr  (addr1),
    .data  (mag2)
  );

  // A stall freezes every stage together, keeping the output word stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      v1         <= 1'b0;
      neg1       <= 1'b0;
      addr1      <= '0;
      ch1        <= '0;
      v2         <= 1'b0;
      neg2       <= 1'b0;
      ch2        <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_ch     <= '0;
    end else if (!stall) begin
      if (issue) begin
        ptr <= (ptr == CH_W'(N_CH - 1)) ? '0 : ptr + CH_W'(1);
      end
      v1         <= enable;
      neg1       <= quad[1];
      addr1      <= addr_fold;
      ch1        <= ptr;
      v2         <= v1;
      neg2       <= neg1;
      ch2        <= ch1;
      out_valid  <= v2;
      out_sample <= neg2 ? (SINE_W'(0) - mag_ext) : mag_ext;
      out_ch     <= ch2;
    end
  end

endmodule

// File: tb/tb_multi_channel_dds.sv
// Directed bench for multi_channel_dds: a channel-state model pushes expected
// samples at issue time, an output monitor pops and compares them on transfer.
module tb_multi_channel_dds;
  import dds_pkg::*;

  localparam int N_CH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [1:0]  cfg_sel = '0;
  logic [23:0] cfg_data = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [11:0] out_sample;
  logic [1:0]  out_ch;

  always #5 clock = ~clock;

  multi_channel_dds dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_ch     (out_ch)
  );

  typedef struct {
    int ch;
    int sample;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [23:0] m_acc [N_CH];
  logic [23:0] m_ftw [N_CH];
  logic [23:0] m_off [N_CH];
  logic [23:0] m_ph;
  int          m_ptr = 0;

  // Hand-computed ROM entries for the phases this bench visits.
  function automatic int expected_sample(input logic [23:0] ph);
    logic [1:0] q;
    logic [7:0] a;
    int         mag;
    q = ph[23:22];
    a = ph[21:14];
    if (q[0]) a = ~a;
    case (a)
      8'd0:    mag = 6;
      8'd127:  mag = 1443;
      8'd128:  mag = 1452;
      8'd255:  mag = 2047;
      default: mag = -100000;
    endcase
    return q[1] ? -mag : mag;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Model: predicts what the upcoming rising edge issues, then applies config.
  always @(negedge clock or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_ptr = 0;
      for (int c = 0; c < N_CH; c++) begin
        m_acc[c] = '0;
        m_ftw[c] = '0;
        m_off[c] = '0;
      end
    end else begin
      if (enable && !(out_valid && !out_ready)) begin
        exp_t e;
        m_ph     = m_acc[m_ptr] + m_off[m_ptr];
        e.ch     = m_ptr;
        e.sample = expected_sample(m_ph);
        exp_q.push_back(e);
        m_acc[m_ptr] = m_acc[m_ptr] + m_ftw[m_ptr];
        m_ptr        = (m_ptr + 1) % N_CH;
      end
      if (cfg_we && (int'(cfg_ch) < N_CH)) begin
        case (cfg_sel)
          2'd0:    m_ftw[cfg_ch] = cfg_data;
          2'd1:    m_off[cfg_ch] = cfg_data;
          2'd2:    m_acc[cfg_ch] = '0;
          default: ;
        endcase
      end
    end
  end

  // Monitor: every valid cycle is compared; the entry is retired on transfer.
  always @(negedge clock) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got ch %0d sample %0d, expected no output",
                 out_ch, $signed(out_sample));
      end else begin
        $display("sample ch %0d = %0d (expected ch %0d = %0d)%s", out_ch,
                 $signed(out_sample), exp_q[0].ch, exp_q[0].sample, out_ready ? "" : " stalled");
        check("out_ch", int'(out_ch), exp_q[0].ch);
        check("out_sample", int'($signed(out_sample)), exp_q[0].sample);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input int ch, input cfg_sel_e sel, input logic [23:0] data);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_sel  = sel;
    cfg_data = data;
    tick(1);
    cfg_we   = 1'b0;
  endtask

  initial begin
    int found;

    // Reset state and first-sample latency, all channels at rest.
    tick(3);
    reset = 1'b0;
    check("reset_valid", int'(out_valid), 0);
    check("reset_sample", int'(out_sample), 0);
    check("reset_ch", int'(out_ch), 0);
    tick(1);
    enable = 1'b1;
    tick(1);
    check("latency_c1", int'(out_valid), 0);
    tick(1);
    check("latency_c2", int'(out_valid), 0);
    tick(1);
    check("latency_c3", int'(out_valid), 1);
    check("first_ch", int'(out_ch), 0);
    tick(12);

    // Quarter-period step on ch0.
    cfg_write(0, CFG_FTW, 24'h400000);
    tick(16);

    // Phase offsets on ch1, then a mixed ftw/offset on ch3.
    cfg_write(1, CFG_OFF, 24'h400000);
    tick(8);
    cfg_write(1, CFG_OFF, 24'hC00000);
    tick(8);
    cfg_write(3, CFG_FTW, 24'h400000);
    cfg_write(3, CFG_OFF, 24'h200000);
    tick(12);

    // Enable pause: pipeline drains, then resumes phase-continuously.
    enable = 1'b0;
    tick(4);
    check("drained_valid", int'(out_valid), 0);
    enable = 1'b1;
    tick(8);

    // Backpressure for five cycles.
    out_ready = 1'b0;
    tick(1);
    check("stall_valid", int'(out_valid), 1);
    tick(4);
    out_ready = 1'b1;
    tick(12);

    // Decrementing accumulator, then clear in the cycle ch2 issues.
    cfg_write(2, CFG_FTW, 24'hFFFFFF);
    tick(16);
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      if (m_ptr == 2) begin
        found = 1;
        cfg_write(2, CFG_CLR, 24'h0);
      end else begin
        tick(1);
      end
    end
    check("clear_aligned", found, 1);
    tick(12);

    // Asynchronous reset while streaming.
    check("pre_reset_valid", int'(out_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_valid", int'(out_valid), 0);
    check("async_reset_sample", int'(out_sample), 0);
    check("async_reset_ch", int'(out_ch), 0);
    tick(2);
    reset = 1'b0;
    tick(3);
    check("restart_valid", int'(out_valid), 1);
    check("restart_ch", int'(out_ch), 0);
    tick(8);

    enable = 1'b0;
    tick(6);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_valid", int'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
